riscv_mem_arbiter: RTL and testbench

- Arbitrates the instruction-cache and data-cache refill/writeback traffic onto the single mem_req/mem_resp port that BackupMemory serves.
- Sits inside riscv_top, directly upstream of the memory interface. Drives mem_req_* and mem_req_data_*; consumes mem_resp_*.
- Steers responses back to the originating cache using the tag MSB.

---
 rtl/riscv_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Merges I-cache refill reads and D-cache refill reads / writebacks onto the
//   single memory request port, and steers memory response beats back to the
//   originating cache using the tag MSB (0 = I-cache, 1 = D-cache).
//
// Ports
//   clk, reset                      clock (rising edge), async active-low reset
//   ic_req_*                        I-cache read request (valid/ready, addr, tag)
//   dc_req_*                        D-cache request (valid/ready, rw, addr, tag)
//   dc_req_data_*                   D-cache write beats (valid/ready, bits, mask)
//   mem_req_*                       merged request (valid/ready, rw, addr, tag)
//   mem_req_data_*                  write beats to memory (+ beat offset)
//   mem_resp_*                      response beats from memory
//   ic_resp_*, dc_resp_*            response beats routed to each cache
//   o_dbg_state                     1 while the write-data phase is active
//   o_dbg_outstanding               reads currently in flight
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holds valid and its
// payload stable until the transfer; ready may depend combinationally on
// valid (request grant is combinational), and valid never depends on ready.
// While reset is 0 every valid and ready output is held at 0.
module riscv_mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = 128,
  parameter int TAG_BITS        = 5,
  parameter int DATA_BEATS      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int OFF_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  // I-cache request
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic [TAG_BITS-2:0]    ic_req_tag,
  // D-cache request
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic                   dc_req_rw,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic [TAG_BITS-2:0]    dc_req_tag,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  // Memory request
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic [OFF_W-1:0]       mem_req_data_offset,
  // Memory response
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  // Routed responses
  output logic                   ic_resp_valid,
  output logic [TAG_BITS-2:0]    ic_resp_tag,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  output logic                   dc_resp_valid,
  output logic [TAG_BITS-2:0]    dc_resp_tag,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  // Debug visibility
  output logic                   o_dbg_state,
  output logic [CNT_W-1:0]       o_dbg_outstanding
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE = 1'b0, S_WDATA = 1'b1} state_t;

  state_t           r_state;
  logic [OFF_W-1:0] r_wbeat;
  logic [OFF_W-1:0] r_rbeat;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_last_dc;     // 1 = D-cache got the most recent grant

  logic w_idle;
  logic w_wdata;
  logic w_can_read;
  logic w_ic_elig;
  logic w_dc_elig;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_req_fire;
  logic w_rd_accept;
  logic w_wr_accept;
  logic w_data_fire;
  logic w_resp_last;

  // Gating state decodes with reset forces every valid/ready low while in
  // reset, independent of the register contents.
  assign w_idle  = reset & (r_state == S_IDLE);
  assign w_wdata = reset & (r_state == S_WDATA);

  // Writes get no response, so they are never throttled by the read limit.
  assign w_can_read = (r_outstanding < MAX_CNT);
  assign w_ic_elig  = w_idle & ic_req_valid & w_can_read;
  assign w_dc_elig  = w_idle & dc_req_valid & (dc_req_rw | w_can_read);

  // Round-robin: on a tie the client that did not win last time goes first.
  assign w_grant_dc = w_dc_elig & (~w_ic_elig | ~r_last_dc);
  assign w_grant_ic = w_ic_elig & ~w_grant_dc;

  assign mem_req_valid = w_grant_ic | w_grant_dc;
  assign mem_req_rw    = w_grant_dc & dc_req_rw;
  assign mem_req_addr  = w_grant_dc ? dc_req_addr : ic_req_addr;
  assign mem_req_tag   = w_grant_dc ? {1'b1, dc_req_tag} : {1'b0, ic_req_tag};
  assign ic_req_ready  = w_grant_ic & mem_req_ready;
  assign dc_req_ready  = w_grant_dc & mem_req_ready;

  assign w_req_fire  = mem_req_valid & mem_req_ready;
  assign w_rd_accept = w_req_fire & ~mem_req_rw;
  assign w_wr_accept = w_req_fire & mem_req_rw;

  // Write-data channel is a straight pass-through during the data phase.
  assign mem_req_data_valid  = w_wdata & dc_req_data_valid;
  assign dc_req_data_ready   = w_wdata & mem_req_data_ready;
  assign mem_req_data_bits   = dc_req_data_bits;
  assign mem_req_data_mask   = dc_req_data_mask;
  assign mem_req_data_offset = reset ? r_wbeat : '0;
  assign w_data_fire         = mem_req_data_valid & mem_req_data_ready;

  // Response routing: purely combinational, payload broadcast to both caches.
  assign ic_resp_valid = reset & mem_resp_valid & ~mem_resp_tag[TAG_BITS-1];
  assign dc_resp_valid = reset & mem_resp_valid &  mem_resp_tag[TAG_BITS-1];
  assign ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  // Responses are never interleaved, so one beat counter tracks line ends.
  assign w_resp_last = mem_resp_valid & (r_rbeat == LAST_BEAT);

  assign o_dbg_state       = (r_state == S_WDATA);
  assign o_dbg_outstanding = r_outstanding;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wbeat       <= '0;
      r_rbeat       <= '0;
      r_outstanding <= '0;
      r_last_dc     <= 1'b1;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_wr_accept) begin
          r_state <= S_WDATA;
          r_wbeat <= '0;
        end
      end else if (w_data_fire) begin
        if (r_wbeat == LAST_BEAT) begin
          r_state <= S_IDLE;
          r_wbeat <= '0;
        end else begin
          r_wbeat <= r_wbeat + OFF_W'(1);
        end
      end

      if (w_req_fire) begin
        r_last_dc <= w_grant_dc;
      end

      if (mem_resp_valid) begin
        r_rbeat <= (r_rbeat == LAST_BEAT) ? '0 : r_rbeat + OFF_W'(1);
      end

      // A read accepted in the same cycle a line completes leaves the count
      // unchanged; the zero guard keeps a stray beat from wrapping the count.
      if (w_rd_accept && !w_resp_last) begin
        r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (w_resp_last && !w_rd_accept && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int AB = 32;
  localparam int DB = 64;
  localparam int TB = 5;
  localparam int NB = 4;
  localparam int MO = 4;
  localparam int MB = DB / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          ic_req_valid, ic_req_ready;
  logic [AB-1:0] ic_req_addr;
  logic [TB-2:0] ic_req_tag;
  logic          dc_req_valid, dc_req_ready, dc_req_rw;
  logic [AB-1:0] dc_req_addr;
  logic [TB-2:0] dc_req_tag;
  logic          dc_req_data_valid, dc_req_data_ready;
  logic [DB-1:0] dc_req_data_bits;
  logic [MB-1:0] dc_req_data_mask;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [TB-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic [1:0]    mem_req_data_offset;
  logic          mem_resp_valid;
  logic [TB-1:0] mem_resp_tag;
  logic [DB-1:0] mem_resp_data;
  logic          ic_resp_valid, dc_resp_valid;
  logic [TB-2:0] ic_resp_tag, dc_resp_tag;
  logic [DB-1:0] ic_resp_data, dc_resp_data;
  logic          o_dbg_state;
  logic [2:0]    o_dbg_outstanding;

  riscv_mem_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB),
    .DATA_BEATS(NB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_req_data_offset(mem_req_data_offset),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data),
    .ic_resp_valid(ic_resp_valid), .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .o_dbg_state(o_dbg_state), .o_dbg_outstanding(o_dbg_outstanding)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // exp_q holds the full tag of every read memory has accepted but not yet
  // finished returning; its size is the expected in-flight count.
  logic [TB-1:0] exp_q[$];
  bit            m_in_write;   // a write line has been accepted, beats pending
  int            m_wbeats_done;
  int            m_rbeats_done;
  bit            m_last_dc;
  int            e_win;        // -1 none, 0 ic, 1 dc
  logic [TB-1:0] e_tag;
  logic [AB-1:0] e_addr;
  bit            e_rw;

  function automatic void model_clear();
    exp_q.delete();
    m_in_write    = 0;
    m_wbeats_done = 0;
    m_rbeats_done = 0;
    m_last_dc     = 1;
  endfunction

  function automatic void model_eval();
    bit ic_ok, dc_ok;
    ic_ok = !m_in_write && ic_req_valid && (exp_q.size() < MO);
    dc_ok = !m_in_write && dc_req_valid && (dc_req_rw || exp_q.size() < MO);
    if (ic_ok && dc_ok) e_win = m_last_dc ? 0 : 1;
    else if (ic_ok)     e_win = 0;
    else if (dc_ok)     e_win = 1;
    else                e_win = -1;
    e_tag  = (e_win == 1) ? {1'b1, dc_req_tag} : {1'b0, ic_req_tag};
    e_addr = (e_win == 1) ? dc_req_addr : ic_req_addr;
    e_rw   = (e_win == 1) && dc_req_rw;
  endfunction

  // Applies the effect of the coming clock edge, using the inputs as driven.
  function automatic void model_commit();
    model_eval();
    if (mem_resp_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_underflow: response beat with no read in flight");
      end else begin
        m_rbeats_done++;
        if (m_rbeats_done == NB) begin
          m_rbeats_done = 0;
          void'(exp_q.pop_front());
        end
      end
    end
    if (!m_in_write) begin
      if (e_win >= 0 && mem_req_ready) begin
        m_last_dc = (e_win == 1);
        if (e_rw) begin
          m_in_write    = 1;
          m_wbeats_done = 0;
        end else begin
          exp_q.push_back(e_tag);
        end
      end
    end else if (dc_req_data_valid && mem_req_data_ready) begin
      m_wbeats_done++;
      if (m_wbeats_done == NB) begin
        m_in_write    = 0;
        m_wbeats_done = 0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ic_req_valid = 0; ic_req_addr = '0; ic_req_tag = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    model_clear();
  endtask

  // Model follows the edge; inputs change 1 time unit after it.
  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_resp_beat();
    mem_resp_valid = 1;
    mem_resp_tag   = exp_q[0];
    mem_resp_data  = {$urandom, $urandom};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0;
    ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1;
    dc_req_data_valid = 1; mem_req_data_ready = 1;
    mem_resp_valid = 1; mem_resp_tag = 5'h10;
    #2;
    checks++;
    if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_data_valid,
         dc_req_data_ready, ic_resp_valid, dc_resp_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b required 0000000",
               {mem_req_valid, ic_req_ready, dc_req_ready, mem_req_data_valid,
                dc_req_data_ready, ic_resp_valid, dc_resp_valid});
    end
    checks++;
    if (mem_req_data_offset !== 2'd0 || o_dbg_state !== 1'b0 || o_dbg_outstanding !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: offset=%0d state=%0d outstanding=%0d required 0/0/0",
               mem_req_data_offset, o_dbg_state, o_dbg_outstanding);
    end
    apply_reset();
  endtask

  task automatic test_ic_read();
    apply_reset();
    ic_req_valid = 1; ic_req_addr = 32'h100; ic_req_tag = 4'd3; mem_req_ready = 1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_tag !== 5'h03 || mem_req_rw !== 1'b0 ||
        mem_req_addr !== 32'h100 || ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ic_read_req: valid=%0d tag=%0h rw=%0d addr=%0h rdy=%0d required 1/03/0/100/1",
               mem_req_valid, mem_req_tag, mem_req_rw, mem_req_addr, ic_req_ready);
    end
    step();
    ic_req_valid = 0;
    for (int b = 0; b < NB; b++) begin
      drive_resp_beat();
      @(negedge clk);
      checks++;
      if (ic_resp_valid !== 1'b1 || dc_resp_valid !== 1'b0 || ic_resp_tag !== 4'd3 ||
          ic_resp_data !== mem_resp_data) begin
        errors++;
        $display("FAIL ic_read_beat%0d: ic_v=%0d dc_v=%0d tag=%0h required 1/0/3", b,
                 ic_resp_valid, dc_resp_valid, ic_resp_tag);
      end
      checks++;
      if (o_dbg_outstanding !== 3'd1) begin
        errors++;
        $display("FAIL ic_read_outstanding_beat%0d: got %0d required 1", b, o_dbg_outstanding);
      end
      step();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if (o_dbg_outstanding !== 3'd0) begin
      errors++;
      $display("FAIL ic_read_drained: outstanding got %0d required 0", o_dbg_outstanding);
    end
  endtask

  task automatic test_round_robin();
    logic [TB-1:0] want_tag[4];
    want_tag = '{5'h02, 5'h15, 5'h02, 5'h15};
    apply_reset();
    dc_req_valid = 1; dc_req_rw = 0; dc_req_tag = 4'd5; dc_req_addr = 32'h80;
    ic_req_valid = 1; ic_req_tag = 4'd2; ic_req_addr = 32'h100; mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tag !== want_tag[i] || mem_req_tag !== e_tag ||
          mem_req_addr !== e_addr) begin
        errors++;
        $display("FAIL rr_grant%0d: tag got %0h required %0h addr got %0h required %0h",
                 i, mem_req_tag, want_tag[i], mem_req_addr, e_addr);
      end
      checks++;
      if (ic_req_ready !== (i % 2 == 0) || dc_req_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_ready%0d: ic=%0d dc=%0d required ic=%0d", i,
                 ic_req_ready, dc_req_ready, (i % 2 == 0));
      end
      step();
    end
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    ic_req_valid = 1; ic_req_tag = 4'd1; mem_req_ready = 1;
    repeat (MO) step();
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b0 || mem_req_valid !== 1'b0 || o_dbg_outstanding !== 3'(MO)) begin
      errors++;
      $display("FAIL limit_block_ic: ic_rdy=%0d mem_v=%0d outstanding=%0d required 0/0/%0d",
               ic_req_ready, mem_req_valid, o_dbg_outstanding, MO);
    end
    step();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h40; dc_req_tag = 4'd7;
    @(negedge clk);
    checks++;
    if (dc_req_ready !== 1'b1 || mem_req_rw !== 1'b1 || ic_req_ready !== 1'b0 ||
        mem_req_tag !== 5'h17) begin
      errors++;
      $display("FAIL limit_write_ok: dc_rdy=%0d rw=%0d ic_rdy=%0d tag=%0h required 1/1/0/17",
               dc_req_ready, mem_req_rw, ic_req_ready, mem_req_tag);
    end
    step();
    dc_req_valid = 0; dc_req_data_valid = 1; mem_req_data_ready = 1;
    repeat (NB) step();
    dc_req_data_valid = 0;
    for (int b = 0; b < NB; b++) begin
      drive_resp_beat();
      @(negedge clk);
      checks++;
      if (ic_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL limit_still_blocked%0d: ic_rdy got %0d required 0", b, ic_req_ready);
      end
      step();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b1 || o_dbg_outstanding !== 3'(MO - 1)) begin
      errors++;
      $display("FAIL limit_released: ic_rdy=%0d outstanding=%0d required 1/%0d",
               ic_req_ready, o_dbg_outstanding, MO - 1);
    end
    ic_req_valid = 0;
    step();
  endtask

  task automatic test_write_data();
    logic [DB-1:0] beat_data[NB];
    int k;
    int cyc;
    bit rdy;
    for (int i = 0; i < NB; i++) beat_data[i] = {$urandom, $urandom};
    apply_reset();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h40; dc_req_tag = 4'd2; mem_req_ready = 1;
    @(negedge clk);
    checks++;
    if (dc_req_ready !== 1'b1 || mem_req_addr !== 32'h40 || mem_req_rw !== 1'b1) begin
      errors++;
      $display("FAIL write_accept: dc_rdy=%0d addr=%0h rw=%0d required 1/40/1",
               dc_req_ready, mem_req_addr, mem_req_rw);
    end
    step();
    dc_req_valid = 0; ic_req_valid = 1; ic_req_tag = 4'd6;
    dc_req_data_valid = 1;
    k = 0; cyc = 0;
    while (k < NB && cyc < 20) begin
      rdy = (cyc % 2 == 0);
      mem_req_data_ready = rdy;
      dc_req_data_bits = beat_data[k];
      dc_req_data_mask = MB'($urandom);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0 || ic_req_ready !== 1'b0 || mem_req_data_valid !== 1'b1 ||
          dc_req_data_ready !== rdy) begin
        errors++;
        $display("FAIL write_phase%0d: mem_v=%0d ic_rdy=%0d data_v=%0d data_rdy=%0d required 0/0/1/%0d",
                 cyc, mem_req_valid, ic_req_ready, mem_req_data_valid, dc_req_data_ready, rdy);
      end
      checks++;
      if (mem_req_data_offset !== 2'(k) || mem_req_data_bits !== beat_data[k] ||
          mem_req_data_mask !== dc_req_data_mask) begin
        errors++;
        $display("FAIL write_beat%0d: offset got %0d required %0d bits got %0h required %0h",
                 k, mem_req_data_offset, k, mem_req_data_bits, beat_data[k]);
      end
      step();
      if (rdy) k++;
      cyc++;
    end
    checks++;
    if (k != NB) begin
      errors++;
      $display("FAIL write_timeout: beats got %0d required %0d", k, NB);
    end
    dc_req_data_valid = 0;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b1 || mem_req_tag !== 5'h06 || mem_req_data_offset !== 2'd0) begin
      errors++;
      $display("FAIL write_done_ic: ic_rdy=%0d tag=%0h offset=%0d required 1/06/0",
               ic_req_ready, mem_req_tag, mem_req_data_offset);
    end
    ic_req_valid = 0;
    step();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    ic_req_valid = 1; ic_req_tag = 4'd4; mem_req_ready = 1;
    step();
    ic_req_valid = 0;
    for (int b = 0; b < NB - 1; b++) begin
      drive_resp_beat();
      step();
    end
    drive_resp_beat();
    ic_req_valid = 1; ic_req_tag = 4'd7;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b1 || ic_resp_valid !== 1'b1 || o_dbg_outstanding !== 3'd1) begin
      errors++;
      $display("FAIL same_cycle_pre: ic_rdy=%0d resp_v=%0d outstanding=%0d required 1/1/1",
               ic_req_ready, ic_resp_valid, o_dbg_outstanding);
    end
    step();
    ic_req_valid = 0; mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if (o_dbg_outstanding !== 3'd1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL same_cycle_post: outstanding got %0d required 1", o_dbg_outstanding);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h80; dc_req_tag = 4'd1; mem_req_ready = 1;
    step();
    dc_req_valid = 0; dc_req_data_valid = 1; mem_req_data_ready = 1;
    repeat (2) step();
    ic_req_valid = 1; dc_req_valid = 1; mem_resp_valid = 1; mem_resp_tag = 5'h11;
    reset = 0;
    #1;
    checks++;
    if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_data_valid,
         dc_req_data_ready, ic_resp_valid, dc_resp_valid} !== 7'b0) begin
      errors++;
      $display("FAIL midwrite_reset_outputs: got %b required 0000000",
               {mem_req_valid, ic_req_ready, dc_req_ready, mem_req_data_valid,
                dc_req_data_ready, ic_resp_valid, dc_resp_valid});
    end
    checks++;
    if (mem_req_data_offset !== 2'd0 || o_dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_reset_state: offset=%0d state=%0d required 0/0",
               mem_req_data_offset, o_dbg_state);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1;
    model_clear();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'hC0; mem_req_ready = 1;
    @(negedge clk);
    checks++;
    if (dc_req_ready !== 1'b1 || o_dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_restart_accept: dc_rdy=%0d state=%0d required 1/0",
               dc_req_ready, o_dbg_state);
    end
    step();
    dc_req_valid = 0; dc_req_data_valid = 1; mem_req_data_ready = 1;
    @(negedge clk);
    checks++;
    if (mem_req_data_valid !== 1'b1 || mem_req_data_offset !== 2'd0) begin
      errors++;
      $display("FAIL midwrite_restart_beat0: data_v=%0d offset=%0d required 1/0",
               mem_req_data_valid, mem_req_data_offset);
    end
    step();
  endtask

  task automatic test_random();
    bit exp_ic_resp, exp_dc_resp;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      ic_req_valid       = ($urandom_range(0, 9) < 7);
      ic_req_addr        = $urandom;
      ic_req_tag         = TB'($urandom) & 4'hF;
      dc_req_valid       = ($urandom_range(0, 1) == 1);
      dc_req_rw          = ($urandom_range(0, 2) == 0);
      dc_req_addr        = $urandom;
      dc_req_tag         = TB'($urandom) & 4'hF;
      dc_req_data_valid  = ($urandom_range(0, 3) != 0);
      dc_req_data_bits   = {$urandom, $urandom};
      dc_req_data_mask   = MB'($urandom);
      mem_req_ready      = ($urandom_range(0, 3) != 0);
      mem_req_data_ready = ($urandom_range(0, 2) != 0);
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) drive_resp_beat();
      else mem_resp_valid = 0;
      @(negedge clk);
      model_eval();
      exp_ic_resp = mem_resp_valid && exp_q.size() > 0 && !exp_q[0][TB-1];
      exp_dc_resp = mem_resp_valid && exp_q.size() > 0 &&  exp_q[0][TB-1];
      checks++;
      if (mem_req_valid !== (e_win >= 0) || ic_req_ready !== (e_win == 0 && mem_req_ready) ||
          dc_req_ready !== (e_win == 1 && mem_req_ready)) begin
        errors++;
        $display("FAIL rand_grant c%0d: mem_v=%0d ic_rdy=%0d dc_rdy=%0d required winner %0d",
                 c, mem_req_valid, ic_req_ready, dc_req_ready, e_win);
      end
      if (e_win >= 0) begin
        checks++;
        if (mem_req_tag !== e_tag || mem_req_addr !== e_addr || mem_req_rw !== e_rw) begin
          errors++;
          $display("FAIL rand_req c%0d: tag=%0h addr=%0h rw=%0d required %0h/%0h/%0d",
                   c, mem_req_tag, mem_req_addr, mem_req_rw, e_tag, e_addr, e_rw);
        end
      end
      checks++;
      if (mem_req_data_valid !== (m_in_write && dc_req_data_valid) ||
          dc_req_data_ready !== (m_in_write && mem_req_data_ready) ||
          mem_req_data_offset !== 2'(m_wbeats_done)) begin
        errors++;
        $display("FAIL rand_data c%0d: data_v=%0d data_rdy=%0d offset=%0d required in_write=%0d beat=%0d",
                 c, mem_req_data_valid, dc_req_data_ready, mem_req_data_offset,
                 m_in_write, m_wbeats_done);
      end
      checks++;
      if (ic_resp_valid !== exp_ic_resp || dc_resp_valid !== exp_dc_resp ||
          (mem_resp_valid && (ic_resp_data !== mem_resp_data || dc_resp_tag !== exp_q[0][TB-2:0]))) begin
        errors++;
        $display("FAIL rand_resp c%0d: ic_v=%0d dc_v=%0d required %0d/%0d",
                 c, ic_resp_valid, dc_resp_valid, exp_ic_resp, exp_dc_resp);
      end
      checks++;
      if (int'(o_dbg_outstanding) != exp_q.size()) begin
        errors++;
        $display("FAIL rand_outstanding c%0d: got %0d required %0d",
                 c, o_dbg_outstanding, exp_q.size());
      end
      step();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    reset = 0;
    model_clear();
    #1;
    test_reset();
    test_ic_read();
    test_round_robin();
    test_outstanding_limit();
    test_write_data();
    test_same_cycle();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
